// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI master, slave and bench: frame layout,
// command/address encodings and register reset values.
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CMD_MSB    = 15;
    localparam int unsigned ADDR_MSB   = 13;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned BIT_IDX_W  = 4;

    localparam logic [DATA_W-1:0] STATUS_RESET = 12'h800;

    typedef enum logic [1:0] {
        CMD_READ  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_SET   = 2'b10,
        CMD_CLEAR = 2'b11
    } adc_cmd_e;

    typedef enum logic [1:0] {
        ADDR_CTRL   = 2'b00,
        ADDR_STATUS = 2'b01,
        ADDR_DATA   = 2'b10,
        ADDR_OFFSET = 2'b11
    } adc_addr_e;

    typedef struct packed {
        logic [1:0]        cmd;
        logic [1:0]        addr;
        logic [DATA_W-1:0] data;
    } adc_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_GAP
    } spi_state_e;

    // READ frames carry a zero payload regardless of the requested data.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0]        cmd,
                                                          input logic [1:0]        addr,
                                                          input logic [DATA_W-1:0] data);
        adc_frame_t f;
        f.cmd  = cmd;
        f.addr = addr;
        f.data = (cmd == CMD_READ) ? '0 : data;
        return f;
    endfunction

endpackage

// File: rtl/adc_spi_sck_gen.sv
// SCK half-period divider: strobes phase_end_c on the last clk cycle of each
// CLK_DIV-cycle half-period while enabled.
module adc_spi_sck_gen #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic phase_end_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign phase_end_c = enable && !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/adc_spi_master.sv
// Cycle-exact SPI master for the ADC register file: one 16-bit frame per
// start request, with CS setup/gap timing and early abort.
module adc_spi_master
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 5,
    parameter int unsigned CS_SETUP = 5,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic [FRAME_BITS-1:0] rx_frame,
    output logic              sck,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned WAIT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_GAP - 1);

    spi_state_e              state, state_d;
    logic [FRAME_BITS-1:0]   tx, tx_d;
    logic [FRAME_BITS-1:0]   rx, rx_d;
    logic [BIT_IDX_W-1:0]    bit_idx, bit_idx_d;
    logic [WAIT_W-1:0]       wcnt, wcnt_d;
    logic                    aborted, aborted_d;
    logic                    cs_d, sck_d, mosi_d, busy_d, done_d;
    logic [DATA_W-1:0]       rd_data_d;
    logic [FRAME_BITS-1:0]   rx_frame_d;
    logic                    sck_en_c;
    logic                    phase_end_c;

    assign sck_en_c = (state == ST_LOW) || (state == ST_HIGH);

    adc_spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (sck_en_c),
        .clear       (abort),
        .phase_end_c (phase_end_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx       <= '0;
            rx       <= '0;
            bit_idx  <= '0;
            wcnt     <= '0;
            aborted  <= 1'b0;
            cs       <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            rx_frame <= '0;
        end else begin
            state    <= state_d;
            tx       <= tx_d;
            rx       <= rx_d;
            bit_idx  <= bit_idx_d;
            wcnt     <= wcnt_d;
            aborted  <= aborted_d;
            cs       <= cs_d;
            sck      <= sck_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
            rd_data  <= rd_data_d;
            rx_frame <= rx_frame_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state;
        tx_d       = tx;
        rx_d       = rx;
        bit_idx_d  = bit_idx;
        wcnt_d     = '0;
        aborted_d  = aborted;
        cs_d       = cs;
        sck_d      = sck;
        mosi_d     = mosi;
        busy_d     = busy;
        done_d     = 1'b0;
        rd_data_d  = rd_data;
        rx_frame_d = rx_frame;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    tx_d      = build_frame(cmd, addr, wr_data);
                    rx_d      = '0;
                    aborted_d = 1'b0;
                    cs_d      = 1'b0;
                    sck_d     = 1'b0;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    cs_d      = 1'b1;
                    sck_d     = 1'b0;
                    mosi_d    = 1'b0;
                    state_d   = ST_GAP;
                end else if (wcnt == SETUP_LAST) begin
                    bit_idx_d = BIT_IDX_W'(FRAME_BITS - 1);
                    mosi_d    = tx[FRAME_BITS-1];
                    state_d   = ST_LOW;
                end else begin
                    wcnt_d = wcnt + WAIT_W'(1);
                end
            end
            ST_LOW: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    cs_d      = 1'b1;
                    sck_d     = 1'b0;
                    mosi_d    = 1'b0;
                    state_d   = ST_GAP;
                end else if (phase_end_c) begin
                    sck_d   = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    cs_d      = 1'b1;
                    sck_d     = 1'b0;
                    mosi_d    = 1'b0;
                    state_d   = ST_GAP;
                end else if (phase_end_c) begin
                    // MISO has been stable since the previous falling edge.
                    rx_d[bit_idx] = miso;
                    sck_d         = 1'b0;
                    if (bit_idx == '0) begin
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        bit_idx_d = bit_idx - BIT_IDX_W'(1);
                        mosi_d    = tx[bit_idx_d];
                        state_d   = ST_LOW;
                    end
                end
            end
            ST_GAP: begin
                if (wcnt == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (!aborted) begin
                        done_d     = 1'b1;
                        rx_frame_d = rx;
                        rd_data_d  = rx[DATA_W-1:0];
                    end
                end else begin
                    wcnt_d = wcnt + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/adc_spi_master.md
Name: adc_spi_master

Overview:
- Synthesizable SPI master that drives the existing adc_spi_slave over the same 16-bit frame: cmd[15:14], addr[13:12], data[11:0].
- Gives on-chip logic (sequencer, SAR control) a simple start/done request port to READ/WRITE/SET/CLEAR the ADC register file.
- Replaces the delay-based bench master with cycle-exact RTL on the system clock.

Parameters:
- CLK_DIV, 5: clk cycles per SCK half-period (SCK = clk/(2*CLK_DIV)); legal range 2..255.
- CS_SETUP, 5: clk cycles from CS falling to the first MOSI bit being presented.
- CS_GAP, 2: minimum clk cycles CS stays high after a frame before done/IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- cmd  in  2  00 READ, 01 WRITE, 10 SET, 11 CLEAR
- addr  in  2  00 CTRL, 01 STATUS, 10 DATA, 11 OFFSET
- wr_data  in  12  payload/bitmask; ignored content for READ (sent as 0x000)
- abort  in  1  terminate the current frame early
- busy  out  1  high from the cycle after start acceptance until return to IDLE
- done  out  1  one-cycle pulse on completed (non-aborted) frame
- rd_data  out  12  rx_frame[11:0] of the last completed frame
- rx_frame  out  16  full 16-bit word shifted in on MISO
- sck  out  1  SPI clock, idle low
- cs  out  1  chip select, active low
- mosi  out  1  serial data to slave
- miso  in  1  serial data from slave

Behaviour:
- Reset values: cs=1, sck=0, mosi=0, busy=0, done=0, rd_data=0x000, rx_frame=0x0000. FSM goes to IDLE and counters clear. Reset mid-frame returns cs high asynchronously.
- All SPI outputs are registered. miso is sampled directly; the slave is synchronous to clk.
- IDLE: when start=1, latch tx={cmd, addr, (cmd==READ ? 12'h000 : wr_data)}. Next cycle: cs=0, sck=0, busy=1, enter SETUP.
- SETUP: hold for CS_SETUP cycles. Then bit_idx=15 and enter LOW.
- LOW: mosi=tx[bit_idx], sck=0 for CLK_DIV cycles, then enter HIGH.
- HIGH: sck=1 for CLK_DIV cycles. The slave captures MOSI on the rising edge. In the last HIGH cycle, rx[bit_idx]=miso, then sck=0.
  - If bit_idx==0, go to GAP.
  - Otherwise decrement bit_idx and go to LOW.
- MOSI changes only while sck is low. MISO is sampled at the end of the high phase, so it is stable since the prior falling edge.
- GAP: cs=1, sck=0, mosi=0 for CS_GAP cycles. Then rx_frame<=rx, rd_data<=rx[11:0], done=1 for one cycle, busy=0, return to IDLE.
- With defaults, cs is low for 5 + 16*10 = 165 clk cycles, and the start-to-done pulse takes 168 cycles.
- start while busy is ignored. It is not queued.
- abort during SETUP/LOW/HIGH: next cycle cs=1, sck=0, mosi=0, enter GAP. At GAP exit there is no done pulse and rd_data/rx_frame are unchanged. abort in IDLE/GAP has no effect.
- start and abort asserted in the same IDLE cycle: start is accepted and abort is ignored.
- The bit counter is 4 bits and stops at 0. The divider counter width is clog2(CLK_DIV).

Decomposition:
- Shared package adc_spi_pkg:
  - CMD_READ/WRITE/SET/CLEAR
  - ADDR_CTRL/STATUS/DATA/OFFSET
  - FRAME_BITS=16, CMD_MSB/ADDR_MSB/DATA_W=12
  - STATUS reset value 12'h800
- The slave and the bench share this package.
- One sub-module is natural: adc_spi_sck_gen. It holds the CLK_DIV divider and issues phase_end strobes, with enable and sync clear. The FSM consumes these strobes.

Test Plan:
- After reset, READ STATUS against the real adc_spi_slave -> done pulse; rd_data=0x800; busy low, cs high in IDLE.
- WRITE CTRL 0xA5A, then READ CTRL -> rd_data=0xA5A; cs low for exactly 165 cycles; exactly 16 sck rising edges per frame.
- WRITE CTRL 0xC33, SET 0x0F0, READ -> 0xCF3. Then WRITE 0xCF3, CLEAR 0xC0C, READ -> 0x0F3.
- WRITE CTRL 0x123, then start WRITE 0xFFF and raise abort after the 10th rising sck -> no done pulse; cs high next cycle; subsequent READ CTRL returns 0x123.
- Pulse start again 20 cycles into a frame -> ignored; exactly one done pulse; rx_frame reflects the first request only.
- Assert reset at bit 7 of a frame -> cs=1, sck=0, busy=0 immediately. After release, READ STATUS returns 0x800.
